selfcheck_monitor: RTL

SELFCHECK_MONITOR -- requirements
Module: selfcheck_monitor

---
 rtl/selfcheck_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/selfcheck_monitor.sv
// Program-end detector and post-run memory self-check.
// Watches the fetch stream for a run of idle instructions, keeps simple
// performance counters up to that point, then scans memory once and
// compares every word against its expected value.
module selfcheck_monitor #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned IDLE_RUN  = 10,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] NOP_INST  = 32'h00000013,
   parameter logic [31:0] LOOP_INST = 32'h0000006f
) (
   input  logic              CLK,
   input  logic              nrst,
   input  logic [31:0]       if_inst,
   input  logic              if_stall,
   input  logic              if_flush,
   output logic [ADDR_W-1:0] con_addr,
   input  logic [DATA_W-1:0] con_out,
   input  logic [DATA_W-1:0] exp_data,
   output logic              done,
   output logic              scan_busy,
   output logic              finished,
   output logic [ADDR_W:0]   pass_count,
   output logic [ADDR_W:0]   fail_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              first_fail_valid,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_cycles,
   output logic [CNT_W-1:0]  max_stall_run
);

   localparam int unsigned IDLE_W = $clog2(IDLE_RUN + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_RUN);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {RUN, SCAN, DRAIN, FIN} state_t;

   state_t              state, state_nxt;
   logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
   logic                is_idle;
   logic [CNT_W-1:0]    stall_run, run_nxt;
   logic [ADDR_W-1:0]   scan_addr;
   logic                issue;
   logic [RD_LAT:1]     vld_pipe;
   logic [RD_LAT:1][ADDR_W-1:0] addr_pipe;
   logic                cmp_vld;
   logic [ADDR_W-1:0]   cmp_addr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // idle-run length of the current fetch, saturating at the end-of-program threshold
   always_comb begin
      is_idle  = (if_inst == NOP_INST) || (if_inst == LOOP_INST);
      idle_nxt = '0;
      if (is_idle)
         idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);
   end

   // idle counter and sticky program-end flag
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         idle_cnt <= '0;
         done     <= 1'b0;
      end else begin
         idle_cnt <= idle_nxt;
         if (idle_nxt == IDLE_MAX)
            done <= 1'b1;
      end
   end

   // length the stall run would have after this cycle
   always_comb begin
      run_nxt = if_stall ? sat_inc(stall_run) : '0;
   end

   // performance counters, all frozen once the program has ended
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         cycle_count   <= '0;
         stall_cycles  <= '0;
         flush_cycles  <= '0;
         stall_run     <= '0;
         max_stall_run <= '0;
      end else if (!done) begin
         cycle_count <= sat_inc(cycle_count);
         if (if_stall)
            stall_cycles <= sat_inc(stall_cycles);
         if (if_flush)
            flush_cycles <= sat_inc(flush_cycles);
         stall_run <= run_nxt;
         if (run_nxt > max_stall_run)
            max_stall_run <= run_nxt;
      end
   end

   // state register
   always_ff @(posedge CLK) begin
      if (!nrst) state <= RUN;
      else       state <= state_nxt;
   end

   // next state: scan once after program end, then wait for the read pipe to empty
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (done)                  state_nxt = SCAN;
         SCAN:    if (scan_addr == LAST_ADDR) state_nxt = DRAIN;
         DRAIN:   if (vld_pipe == '0)         state_nxt = FIN;
         default: state_nxt = FIN;
      endcase
   end

   // state-decoded outputs; the address bus is held at 0 unless scanning
   always_comb begin
      issue     = (state == SCAN);
      scan_busy = (state == SCAN) || (state == DRAIN);
      finished  = (state == FIN);
      con_addr  = issue ? scan_addr : '0;
   end

   // scan address and read-latency pipeline pairing each address with its data
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         scan_addr <= '0;
         vld_pipe  <= '0;
         addr_pipe <= '0;
      end else begin
         if (issue && scan_addr != LAST_ADDR) scan_addr <= scan_addr + ADDR_W'(1);
         else                                 scan_addr <= '0;
         vld_pipe[1]  <= issue;
         addr_pipe[1] <= scan_addr;
         for (int i = 2; i <= int'(RD_LAT); i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
      end
   end

   // data returning this cycle belongs to the oldest pipeline entry
   always_comb begin
      cmp_vld  = vld_pipe[RD_LAT];
      cmp_addr = addr_pipe[RD_LAT];
   end

   // compare results; the scan runs upward so the first mismatch is the lowest address
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         pass_count       <= '0;
         fail_count       <= '0;
         first_fail_addr  <= '0;
         first_fail_valid <= 1'b0;
      end else if (cmp_vld) begin
         if (con_out == exp_data) begin
            pass_count <= pass_count + (ADDR_W+1)'(1);
         end else begin
            fail_count <= fail_count + (ADDR_W+1)'(1);
            if (!first_fail_valid) begin
               first_fail_addr  <= cmp_addr;
               first_fail_valid <= 1'b1;
            end
         end
      end
   end

endmodule
